// File: rtl/display_timing.sv
// Raster timing generator: pixel/line counters with registered sync,
// blanking and start-of-line/frame strobes aligned to curr_x/curr_y.
module display_timing #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 64,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 200,
  parameter int V_ACTIVE = 800,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 22,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic [10:0] curr_x,
  output logic [9:0]  curr_y,
  output logic        active_area,
  output logic        hsync,
  output logic        vsync,
  output logic        vblank,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] XMAX = 11'(H_TOTAL - 1);
  localparam logic [10:0] XACT = 11'(H_ACTIVE);
  localparam logic [10:0] XS0  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] XS1  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [9:0] YMAX = 10'(V_TOTAL - 1);
  localparam logic [9:0] YACT = 10'(V_ACTIVE);
  localparam logic [9:0] YS0  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] YS1  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        act_q, act_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        vb_q, vb_d;
  logic        ls_q, ls_d;
  logic        fs_q, fs_d;
  logic [15:0] fc_q, fc_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_en) begin
      if (x_q == XMAX) begin
        x_d = '0;
        y_d = (y_q == YMAX) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 11'd1;
      end
    end
    // Decode from next-state so flags line up with the counters
    act_d = (x_d < XACT) && (y_d < YACT);
    hs_d  = (x_d >= XS0 && x_d <= XS1) ? H_POL : ~H_POL;
    vs_d  = (y_d >= YS0 && y_d <= YS1) ? V_POL : ~V_POL;
    vb_d  = (y_d >= YACT);
    ls_d  = pix_en && (x_d == '0);
    fs_d  = ls_d && (y_d == '0);
    fc_d  = fs_d ? fc_q + 16'd1 : fc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= XMAX;
      y_q   <= YMAX;
      act_q <= 1'b0;
      hs_q  <= ~H_POL;
      vs_q  <= ~V_POL;
      vb_q  <= 1'b1;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
      fc_q  <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      act_q <= act_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      vb_q  <= vb_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
      fc_q  <= fc_d;
    end
  end

  assign curr_x      = x_q;
  assign curr_y      = y_q;
  assign active_area = act_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign vblank      = vb_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule
